// File: rtl/riscv_pkg.sv
// Shared constants for the instruction-fetch datapath.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [31:0]     RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [ILEN-1:0] NOP_INSTR        = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} pairs that buffers fetched words for decode.
// A flush wins over push and pop in the same cycle.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter int  AW    = XLEN,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_push,
    input  logic [AW-1:0]   i_push_pc,
    input  logic [ILEN-1:0] i_push_instr,
    input  logic            i_pop,
    input  logic            i_flush,
    output logic [AW-1:0]   o_head_pc,
    output logic [ILEN-1:0] o_head_instr,
    output logic [CW-1:0]   o_count,
    output logic            o_full,
    output logic            o_empty
);

    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0]   r_pc_mem    [DEPTH];
    logic [ILEN-1:0] r_instr_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_push;
    logic            w_pop;

    assign o_empty      = (r_count == '0);
    assign o_full       = (r_count == CW'(DEPTH));
    assign w_push       = i_push && !i_flush;
    assign w_pop        = i_pop && !i_flush && !o_empty;
    assign o_count      = r_count;
    assign o_head_pc    = r_pc_mem[r_rd_ptr];
    assign o_head_instr = r_instr_mem[r_rd_ptr];

    // Entry storage is written on push; it needs no reset because count guards reads.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]    <= i_push_pc;
            r_instr_mem[r_wr_ptr] <= i_push_instr;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && o_full && !w_pop));

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues in-order memory requests under a
// credit limit, buffers returned words, and discards stale words after a redirect.
module fetch_stage #(
    parameter int              XLEN       = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = riscv_pkg::RESET_PC_DEFAULT,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic                       imem_req_valid,
    input  logic                       imem_req_ready,
    output logic [XLEN-1:0]            imem_req_addr,
    input  logic                       imem_resp_valid,
    input  logic [riscv_pkg::ILEN-1:0] imem_resp_data,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       id_valid,
    input  logic                       id_ready,
    output logic [riscv_pkg::ILEN-1:0] id_instr,
    output logic [XLEN-1:0]            id_pc,
    output logic [XLEN-1:0]            id_pc_plus4
);

    import riscv_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [XLEN-1:0] r_pc;
    logic [CW-1:0]   r_inflight;
    logic [CW-1:0]   r_drop_cnt;
    logic            r_fetch_en;

    logic [CW-1:0]   w_fifo_count;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic [XLEN-1:0] w_head_pc;
    logic [ILEN-1:0] w_head_instr;
    logic [CW:0]     w_occupancy;
    logic            w_req_fire;
    logic            w_resp_drop;
    logic            w_push;
    logic            w_pop;

    // Credits cover both words still in memory and words already buffered, so the
    // buffer can always absorb every outstanding response.
    assign w_occupancy    = {1'b0, r_inflight} + {1'b0, w_fifo_count};
    assign imem_req_valid = r_fetch_en && !w_fifo_full && !redirect_valid
                            && (w_occupancy < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr  = r_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    // Responses owed to a redirected-away path are thrown away, as is anything
    // arriving in the redirect cycle itself.
    assign w_resp_drop = imem_resp_valid && (r_drop_cnt != '0);
    assign w_push      = imem_resp_valid && (r_drop_cnt == '0) && !redirect_valid;

    assign id_valid    = !w_fifo_empty && !redirect_valid;
    assign w_pop       = id_valid && id_ready;
    assign id_instr    = w_fifo_empty ? NOP_INSTR : w_head_instr;
    assign id_pc       = w_fifo_empty ? RESET_PC : w_head_pc;
    assign id_pc_plus4 = id_pc + XLEN'(4);

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .AW    (XLEN)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push       (w_push),
        .i_push_pc    (w_head_pc_src()),
        .i_push_instr (imem_resp_data),
        .i_pop        (w_pop),
        .i_flush      (redirect_valid),
        .o_head_pc    (w_head_pc),
        .o_head_instr (w_head_instr),
        .o_count      (w_fifo_count),
        .o_full       (w_fifo_full),
        .o_empty      (w_fifo_empty)
    );

    // Requests return in order, so the PC of the word being returned is the PC of
    // the oldest outstanding request: current PC minus four per outstanding request.
    function automatic logic [XLEN-1:0] w_head_pc_src();
        return r_pc - (XLEN'(r_inflight) << 2);
    endfunction

    // Hold off the first request until one cycle after reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_fetch_en <= 1'b0;
        else        r_fetch_en <= 1'b1;
    end

    // Program counter: redirect target (word aligned) or sequential advance on issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= {redirect_pc[XLEN-1:2], 2'b00};
        end else if (w_req_fire) begin
            r_pc <= r_pc + XLEN'(4);
        end
    end

    // Outstanding-request count and the number of those still owed to a dead path;
    // on redirect every request still outstanding after this cycle becomes stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_inflight <= r_inflight + CW'(w_req_fire) - CW'(imem_resp_valid);
            if (redirect_valid) begin
                r_drop_cnt <= r_inflight - CW'(imem_resp_valid);
            end else begin
                r_drop_cnt <= r_drop_cnt - CW'(w_resp_drop);
            end
        end
    end

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(imem_resp_valid && (r_inflight == '0)));

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a queue-based memory/fetch model, directed
// scenarios pinned with hand-computed values, then randomized traffic.
module tb_fetch_stage;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RST_PC   = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;

    fetch_stage #(
        .XLEN       (32),
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_instr        (id_instr),
        .id_pc           (id_pc),
        .id_pc_plus4     (id_pc_plus4)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        bit          stale;
        int          readyCycle;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    req_t        outQ[$];
    ent_t        fifoQ[$];
    logic [31:0] mPc;
    bit          mStarted;
    int          cycle;

    int          kReqReadyPct;
    int          kRespPct;
    int          kIdReadyPct;
    int          kRedirectPct;
    int          kLatMin;
    int          kLatMax;
    bit          fRedirect;
    logic [31:0] fRedirectPc;

    logic [31:0] deliveredPc[$];
    logic [31:0] deliveredPc4[$];
    int          firstValidCycle;
    int          reqCount;
    logic        lastReqValid;
    logic [31:0] lastReqAddr;

    int          nChecks;
    int          nPass;

    // Word stored in memory at a given address, distinct from the address itself.
    function automatic logic [31:0] memData(input logic [31:0] addr);
        return {addr[15:0], addr[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] getQ(input logic [31:0] q[$], input int idx);
        if (idx < q.size()) return q[idx];
        return 32'hxxxx_xxxx;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual === expected) nPass++;
        else $display("[TB] FAIL %s actual=%h expected=%h (cycle %0d)", name, actual, expected, cycle);
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        nChecks++;
        if (actual === expected) nPass++;
        else $display("[TB] FAIL %s actual=%b expected=%b (cycle %0d)", name, actual, expected, cycle);
    endtask

    task automatic checkResetValues(input string tag);
        checkBit({tag, "_req_valid"}, imem_req_valid, 1'b0);
        checkBit({tag, "_id_valid"}, id_valid, 1'b0);
        check({tag, "_id_instr"}, id_instr, 32'h0000_0013);
        check({tag, "_id_pc"}, id_pc, 32'h0000_0000);
        check({tag, "_id_pc_plus4"}, id_pc_plus4, 32'h0000_0004);
    endtask

    task automatic driveIdle();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        id_ready        = 1'b0;
    endtask

    task automatic clearModel();
        outQ.delete();
        fifoQ.delete();
        deliveredPc.delete();
        deliveredPc4.delete();
        mPc             = RST_PC;
        mStarted        = 1'b0;
        cycle           = 0;
        firstValidCycle = -1;
        reqCount        = 0;
        fRedirect       = 1'b0;
    endtask

    // Drive all inputs for one cycle from the current knobs and the memory queue.
    task automatic applyStimulus();
        id_ready       = ($urandom_range(0, 99) < kIdReadyPct);
        imem_req_ready = ($urandom_range(0, 99) < kReqReadyPct);
        if (fRedirect) begin
            redirect_valid = 1'b1;
            redirect_pc    = fRedirectPc;
            fRedirect      = 1'b0;
        end else if ($urandom_range(0, 99) < kRedirectPct) begin
            redirect_valid = 1'b1;
            redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + $urandom_range(0, 15)) : $urandom;
        end else begin
            redirect_valid = 1'b0;
            redirect_pc    = $urandom;
        end
        if (outQ.size() > 0 && outQ[0].readyCycle <= cycle && $urandom_range(0, 99) < kRespPct) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = memData(outQ[0].addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
    endtask

    // Compare DUT outputs with the model, then advance the model by one clock.
    task automatic checkOutput();
        bit   expReqValid;
        bit   expIdValid;
        bit   reqFire;
        bit   idFire;
        req_t r;
        expReqValid = mStarted && (outQ.size() + fifoQ.size() < DEPTH) && !redirect_valid;
        expIdValid  = (fifoQ.size() > 0) && !redirect_valid;
        checkBit("req_valid", imem_req_valid, expReqValid);
        if (expReqValid) check("req_addr", imem_req_addr, mPc);
        checkBit("id_valid", id_valid, expIdValid);
        if (expIdValid) begin
            check("id_instr", id_instr, fifoQ[0].instr);
            check("id_pc", id_pc, fifoQ[0].pc);
            check("id_pc_plus4", id_pc_plus4, fifoQ[0].pc + 32'd4);
        end
        lastReqValid = imem_req_valid;
        lastReqAddr  = imem_req_addr;
        if (id_valid === 1'b1 && firstValidCycle < 0) firstValidCycle = cycle;
        reqFire = expReqValid && imem_req_ready;
        idFire  = expIdValid && id_ready;
        if (id_valid === 1'b1 && id_ready) begin
            deliveredPc.push_back(id_pc);
            deliveredPc4.push_back(id_pc_plus4);
        end
        if (reqFire) reqCount++;
        if (redirect_valid) begin
            foreach (outQ[i]) outQ[i].stale = 1'b1;
            fifoQ.delete();
            mPc = {redirect_pc[31:2], 2'b00};
            if (imem_resp_valid) void'(outQ.pop_front());
        end else begin
            if (idFire) void'(fifoQ.pop_front());
            if (imem_resp_valid) begin
                r = outQ.pop_front();
                if (!r.stale) fifoQ.push_back('{r.addr, memData(r.addr)});
            end
            if (reqFire) begin
                outQ.push_back('{mPc, 1'b0, cycle + int'($urandom_range(kLatMax, kLatMin))});
                mPc = mPc + 32'd4;
            end
        end
        mStarted = 1'b1;
        cycle++;
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            applyStimulus();
            #1;
            checkOutput();
        end
    endtask

    task automatic setKnobs(input int rr, input int rs, input int ir, input int rd, input int lmin, input int lmax);
        kReqReadyPct = rr;
        kRespPct     = rs;
        kIdReadyPct  = ir;
        kRedirectPct = rd;
        kLatMin      = lmin;
        kLatMax      = lmax;
    endtask

    // Reset held across clock edges, released just after a rising edge.
    task automatic resetDut(input string tag);
        @(negedge clk);
        driveIdle();
        rst_n = 1'b0;
        #1;
        checkResetValues(tag);
        @(posedge clk);
        @(posedge clk);
        clearModel();
        #2 rst_n = 1'b1;
    endtask

    // Reset asserted between edges; outputs must change before any clock edge.
    task automatic asyncReset(input string tag);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkResetValues(tag);
        driveIdle();
        @(posedge clk);
        clearModel();
        #2 rst_n = 1'b1;
    endtask

    initial begin
        nChecks = 0;
        nPass   = 0;
        rst_n   = 1'b1;
        driveIdle();
        clearModel();
        setKnobs(100, 100, 100, 0, 1, 1);

        // Straight-line fetch with an ideal memory and decode.
        resetDut("t1_reset");
        setKnobs(100, 100, 100, 0, 1, 1);
        runCycles(14);
        check("t1_first_valid_cycle", firstValidCycle, 32'd3);
        check("t1_pc0", getQ(deliveredPc, 0), 32'h0);
        check("t1_pc1", getQ(deliveredPc, 1), 32'h4);
        check("t1_pc2", getQ(deliveredPc, 2), 32'h8);
        check("t1_pc4_0", getQ(deliveredPc4, 0), 32'h4);

        // Decode stalled: the credit cap limits issue to two requests.
        resetDut("t2_reset");
        setKnobs(100, 100, 0, 0, 1, 1);
        runCycles(10);
        check("t2_req_count", reqCount, 32'd2);
        checkBit("t2_req_blocked", lastReqValid, 1'b0);
        kIdReadyPct = 100;
        runCycles(12);
        check("t2_pc0", getQ(deliveredPc, 0), 32'h0);
        check("t2_pc1", getQ(deliveredPc, 1), 32'h4);
        check("t2_pc2", getQ(deliveredPc, 2), 32'h8);

        // Redirect with two requests outstanding: both stale words vanish.
        resetDut("t3_reset");
        setKnobs(100, 100, 100, 0, 4, 4);
        runCycles(3);
        fRedirect   = 1'b1;
        fRedirectPc = 32'h0000_0100;
        runCycles(20);
        check("t3_pc0", getQ(deliveredPc, 0), 32'h100);
        check("t3_pc1", getQ(deliveredPc, 1), 32'h104);

        // Redirect coinciding with a response and a decode-ready buffered word.
        resetDut("t4_reset");
        setKnobs(100, 100, 0, 0, 1, 1);
        runCycles(3);
        fRedirect   = 1'b1;
        fRedirectPc = 32'h0000_0200;
        kIdReadyPct = 100;
        runCycles(1);
        check("t4_delivered_none", deliveredPc.size(), 32'd0);
        runCycles(1);
        checkBit("t4_next_req_valid", lastReqValid, 1'b1);
        check("t4_next_req_addr", lastReqAddr, 32'h200);
        runCycles(8);
        check("t4_pc0", getQ(deliveredPc, 0), 32'h200);

        // Misaligned redirect target is word-aligned.
        resetDut("t5a_reset");
        setKnobs(100, 100, 100, 0, 1, 1);
        fRedirect   = 1'b1;
        fRedirectPc = 32'h0000_0103;
        runCycles(2);
        check("t5_aligned_addr", lastReqAddr, 32'h100);
        runCycles(6);
        check("t5_aligned_pc0", getQ(deliveredPc, 0), 32'h100);

        // PC wraps past the top of the address space.
        resetDut("t5b_reset");
        fRedirect   = 1'b1;
        fRedirectPc = 32'hFFFF_FFFE;
        runCycles(12);
        check("t5_wrap_pc0", getQ(deliveredPc, 0), 32'hFFFF_FFFC);
        check("t5_wrap_pc4_0", getQ(deliveredPc4, 0), 32'h0);
        check("t5_wrap_pc1", getQ(deliveredPc, 1), 32'h0);

        // Asynchronous reset with two requests in flight, then with a full buffer.
        resetDut("t6_reset");
        setKnobs(100, 100, 100, 0, 4, 4);
        runCycles(3);
        asyncReset("t6_inflight");
        setKnobs(100, 100, 100, 0, 1, 1);
        runCycles(8);
        check("t6_restart_pc0", getQ(deliveredPc, 0), 32'h0);
        setKnobs(100, 100, 0, 0, 1, 1);
        runCycles(6);
        asyncReset("t6_full");
        setKnobs(100, 100, 100, 0, 1, 1);
        runCycles(8);
        check("t6b_restart_pc0", getQ(deliveredPc, 0), 32'h0);

        // Randomized traffic in several flavours, with an async reset in the middle.
        resetDut("rnd_reset");
        setKnobs(70, 70, 70, 5, 1, 4);
        runCycles(1500);
        setKnobs(40, 90, 30, 8, 1, 6);
        runCycles(1500);
        asyncReset("rnd_async");
        setKnobs(90, 50, 90, 3, 1, 3);
        runCycles(1500);
        setKnobs(100, 100, 100, 15, 1, 2);
        runCycles(1500);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
